dkong_snd_rom_arb: RTL and testbench
====================================

DKONG_SND_ROM_ARB -- requirements
Module: dkong_snd_rom_arb

Interface
REQ-001 Parameter: CPU_BASE, default 20'h80000, base address of the 8035 program ROM region in shared memory.
REQ-002 Parameter: TIMEOUT, default 64, maximum clocks to wait for MEM_ACK before abandoning a request.
REQ-003 Clock and reset: clock W_CLK_24576M; reset W_RESETn, asynchronous, active-low.
REQ-004 W_CLK_24576M  in  1  system clock, 24.576 MHz.
REQ-005 W_RESETn  in  1  asynchronous active-low reset.
REQ-006 CPU_A  in  12  8035 program fetch address.
REQ-007 CPU_D  out  8  program byte for the last fetched CPU address.
REQ-008 CPU_VALID  out  1  CPU_D corresponds to the current CPU_A.
REQ-009 WAV_A  in  19  wav sample address.
REQ-010 WAV_D  out  8  sample byte, unsigned.
REQ-011 WAV_VALID  out  1  WAV_D corresponds to the current WAV_A.
REQ-012 MEM_REQ  out  1  shared memory request, level.
REQ-013 MEM_A  out  20  shared memory byte address.
REQ-014 MEM_ACK  in  1  one-cycle pulse; MEM_D valid in the same cycle.
REQ-015 MEM_D  in  8  shared memory read data.
REQ-016 TIMEOUT_ERR  out  1  sticky flag; set on any abandoned request.

Function
REQ-017 Each requester SHALL hold a tag register (last served address) and a valid bit; the requester is pending when its valid bit is 0 or its tag differs from its current input address.
REQ-018 FSM states SHALL be IDLE, CPU_BUSY and WAV_BUSY.
REQ-019 IDLE: if exactly one requester is pending -> that requester's BUSY state; MEM_REQ goes high on the same clock edge.
REQ-020 When both are pending in IDLE, the arbiter SHALL grant the requester not served last (round-robin); after reset, CPU wins first.
REQ-021 On entering a BUSY state, the arbiter SHALL capture the granted address into the tag register; MEM_A SHALL equal CPU_BASE | {8'h00,CPU_A} for CPU and {1'b0,WAV_A} for WAV.
REQ-022 MEM_A SHALL stay stable and MEM_REQ SHALL stay high until MEM_ACK is sampled high or the timeout fires.
REQ-023 On MEM_ACK, the arbiter SHALL: latch MEM_D into the granted data register, set its valid bit, drop MEM_REQ, and return to IDLE, all on the same edge.
REQ-024 Minimum turnaround SHALL be 1 idle cycle between MEM_ACK and the next MEM_REQ rising.
REQ-025 An address change during BUSY SHALL NOT abort the transfer; the stale data SHALL be latched, and the mismatch with the tag SHALL re-raise pending.
REQ-026 xVALID SHALL be combinational: the valid bit AND (tag == current address).
REQ-027 A cycle counter SHALL run in BUSY; if it reaches TIMEOUT-1 without MEM_ACK, the arbiter SHALL:
- load 8'hFF into the CPU data register or 8'h80 into the WAV data register;
- set the valid bit and TIMEOUT_ERR;
- drop MEM_REQ and return to IDLE.
REQ-028 A MEM_ACK received while in IDLE SHALL be ignored.
REQ-029 The round-robin last-served flag SHALL update on every completion or timeout.

Reset
REQ-030 Asserting W_RESETn low SHALL immediately force the following, including mid-transfer:
- state IDLE, MEM_REQ 0, MEM_A 0;
- CPU_D 8'h00, WAV_D 8'h80;
- both valid bits 0, tags 0;
- TIMEOUT_ERR 0, counter 0, last-served = WAV.
REQ-031 After reset release, both requesters SHALL be pending; the CPU SHALL be served first, then WAV.

Verification
REQ-032 Reset release, CPU_A=12'h000, WAV_A=0, memory acks after 3 cycles -> MEM_A=20'h80000 then 20'h00000; CPU_VALID then WAV_VALID rise.
REQ-033 Both addresses change in the same cycle after the last grant was CPU -> WAV is granted first, CPU next; no cycle overlaps two requests.
REQ-034 CPU_A changes 12'h010->12'h011 while CPU_BUSY for 12'h010 -> byte for 010 is latched with CPU_VALID=0, then a new request to 20'h80011 completes with CPU_VALID=1.
REQ-035 MEM_ACK never arrives, TIMEOUT=64 -> MEM_REQ drops after 64 cycles, CPU_D=8'hFF, TIMEOUT_ERR=1 and stays set until reset.
REQ-036 W_RESETn low during WAV_BUSY -> MEM_REQ=0 at once; a stray MEM_ACK after release but before the first request is ignored.

Source files
------------

// File: rtl/dkong_snd_rom_arb.sv
// Sound ROM arbiter: shares one memory port between the 8035 program fetch and the wav sample reader.
// Each requester keeps a one-entry tag/data cache; an empty entry or a tag mismatch triggers a fetch.
module dkong_snd_rom_arb #(
    parameter logic [19:0] CPU_BASE = 20'h80000,
    parameter int          TIMEOUT  = 64
) (
    input  logic        W_CLK_24576M,
    input  logic        W_RESETn,
    input  logic [11:0] CPU_A,
    output logic [7:0]  CPU_D,
    output logic        CPU_VALID,
    input  logic [18:0] WAV_A,
    output logic [7:0]  WAV_D,
    output logic        WAV_VALID,
    output logic        MEM_REQ,
    output logic [19:0] MEM_A,
    input  logic        MEM_ACK,
    input  logic [7:0]  MEM_D,
    output logic        TIMEOUT_ERR
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_BUSY = 2'd1,
        WAV_BUSY = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [11:0]      cpu_tag;
    logic             cpu_vld;
    logic [7:0]       cpu_dat;
    logic [18:0]      wav_tag;
    logic             wav_vld;
    logic [7:0]       wav_dat;
    logic [19:0]      mem_a_r;
    logic [CNT_W-1:0] cnt;
    logic             last_wav;
    logic             timeout_r;

    logic             cpu_pend;
    logic             wav_pend;
    logic             grant_cpu;
    logic             grant_wav;
    logic             ack_done;
    logic             to_done;
    logic             finish;

    assign cpu_pend = !cpu_vld || (cpu_tag != CPU_A);
    assign wav_pend = !wav_vld || (wav_tag != WAV_A);
    assign finish   = ack_done || to_done;

    // Round-robin only matters when both miss: the side not served last wins.
    always_comb begin
        state_nxt = state;
        grant_cpu = 1'b0;
        grant_wav = 1'b0;
        ack_done  = 1'b0;
        to_done   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_pend && (!wav_pend || last_wav)) begin
                    grant_cpu = 1'b1;
                    state_nxt = CPU_BUSY;
                end else if (wav_pend) begin
                    grant_wav = 1'b1;
                    state_nxt = WAV_BUSY;
                end
            end
            CPU_BUSY, WAV_BUSY: begin
                if (MEM_ACK) begin
                    ack_done  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    to_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The tag is captured at grant time, so an address change mid-transfer still
    // completes the old fetch and simply leaves the requester pending afterwards.
    always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            cpu_tag   <= '0;
            cpu_vld   <= 1'b0;
            cpu_dat   <= 8'h00;
            wav_tag   <= '0;
            wav_vld   <= 1'b0;
            wav_dat   <= 8'h80;
            mem_a_r   <= '0;
            cnt       <= '0;
            last_wav  <= 1'b1;
            timeout_r <= 1'b0;
        end else begin
            if (grant_cpu) begin
                cpu_tag <= CPU_A;
                mem_a_r <= CPU_BASE | {8'h00, CPU_A};
            end
            if (grant_wav) begin
                wav_tag <= WAV_A;
                mem_a_r <= {1'b0, WAV_A};
            end

            if ((state != IDLE) && !finish) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end

            if (finish) begin
                last_wav <= (state == WAV_BUSY);
            end
            if ((state == CPU_BUSY) && finish) begin
                cpu_dat <= ack_done ? MEM_D : 8'hFF;
                cpu_vld <= 1'b1;
            end
            if ((state == WAV_BUSY) && finish) begin
                wav_dat <= ack_done ? MEM_D : 8'h80;
                wav_vld <= 1'b1;
            end
            if (to_done) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign MEM_REQ     = (state != IDLE);
    assign MEM_A       = mem_a_r;
    assign CPU_D       = cpu_dat;
    assign WAV_D       = wav_dat;
    assign CPU_VALID   = cpu_vld && (cpu_tag == CPU_A);
    assign WAV_VALID   = wav_vld && (wav_tag == WAV_A);
    assign TIMEOUT_ERR = timeout_r;

endmodule

// File: tb/tb_dkong_snd_rom_arb.sv
// Bench for dkong_snd_rom_arb: a memory responder answers requests, and a monitor
// checks each memory transaction against a queue of hand-computed expected results.
module tb_dkong_snd_rom_arb;

    logic        W_CLK_24576M = 1'b0;
    logic        W_RESETn     = 1'b1;
    logic [11:0] CPU_A        = '0;
    logic [7:0]  CPU_D;
    logic        CPU_VALID;
    logic [18:0] WAV_A        = '0;
    logic [7:0]  WAV_D;
    logic        WAV_VALID;
    logic        MEM_REQ;
    logic [19:0] MEM_A;
    logic        MEM_ACK      = 1'b0;
    logic [7:0]  MEM_D        = '0;
    logic        TIMEOUT_ERR;

    typedef struct {
        logic [19:0] addr;
        logic        is_wav;
        logic [7:0]  data;
        logic        vld;
        int          cycles;
    } exp_t;

    exp_t exp_q[$];
    int   tests     = 0;
    int   failures  = 0;
    int   completed = 0;
    bit   ack_en    = 1'b1;
    int   ack_delay = 3;

    dkong_snd_rom_arb #(.CPU_BASE(20'h80000), .TIMEOUT(64)) dut (
        .W_CLK_24576M (W_CLK_24576M),
        .W_RESETn     (W_RESETn),
        .CPU_A        (CPU_A),
        .CPU_D        (CPU_D),
        .CPU_VALID    (CPU_VALID),
        .WAV_A        (WAV_A),
        .WAV_D        (WAV_D),
        .WAV_VALID    (WAV_VALID),
        .MEM_REQ      (MEM_REQ),
        .MEM_A        (MEM_A),
        .MEM_ACK      (MEM_ACK),
        .MEM_D        (MEM_D),
        .TIMEOUT_ERR  (TIMEOUT_ERR)
    );

    always #20 W_CLK_24576M = ~W_CLK_24576M;

    function automatic logic [7:0] mem_byte(input logic [19:0] a);
        return a[7:0] ^ a[19:12] ^ 8'h5A;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExp(input logic [19:0] a, input logic w, input logic [7:0] d,
                           input logic v, input int c);
        exp_t e;
        e.addr   = a;
        e.is_wav = w;
        e.data   = d;
        e.vld    = v;
        e.cycles = c;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [11:0] cpu_a, input logic [18:0] wav_a);
        @(negedge W_CLK_24576M);
        CPU_A = cpu_a;
        WAV_A = wav_a;
    endtask

    task automatic waitDone(input int target);
        int n = 0;
        while (completed < target && n < 500) begin
            @(negedge W_CLK_24576M);
            n++;
        end
        checkOutput("wait_done", completed, target);
    endtask

    task automatic waitReq();
        int n = 0;
        while (!MEM_REQ && n < 100) begin
            @(negedge W_CLK_24576M);
            n++;
        end
        checkOutput("wait_req", {31'd0, MEM_REQ}, 32'd1);
    endtask

    task automatic checkResetState();
        checkOutput("rst_mem_req", {31'd0, MEM_REQ}, 32'd0);
        checkOutput("rst_mem_a", {12'd0, MEM_A}, 32'h0);
        checkOutput("rst_cpu_d", {24'd0, CPU_D}, 32'h00);
        checkOutput("rst_wav_d", {24'd0, WAV_D}, 32'h80);
        checkOutput("rst_cpu_valid", {31'd0, CPU_VALID}, 32'd0);
        checkOutput("rst_wav_valid", {31'd0, WAV_VALID}, 32'd0);
        checkOutput("rst_timeout_err", {31'd0, TIMEOUT_ERR}, 32'd0);
    endtask

    // Memory model: acknowledges ack_delay sampled cycles after MEM_REQ is seen high.
    initial begin
        int ack_cnt;
        ack_cnt = 0;
        forever begin
            @(negedge W_CLK_24576M);
            if (ack_en) begin
                if (MEM_REQ && !MEM_ACK) begin
                    ack_cnt++;
                    if (ack_cnt == ack_delay) begin
                        MEM_ACK = 1'b1;
                        MEM_D   = mem_byte(MEM_A);
                        ack_cnt = 0;
                    end
                end else begin
                    MEM_ACK = 1'b0;
                    ack_cnt = 0;
                end
            end
        end
    end

    // Monitor: each MEM_REQ rise claims the next expected transaction, each fall checks its result.
    initial begin
        bit   prev_req;
        bit   have_cur;
        int   hi_cycles;
        exp_t cur;
        prev_req  = 1'b0;
        have_cur  = 1'b0;
        hi_cycles = 0;
        forever begin
            @(negedge W_CLK_24576M);
            if (MEM_REQ && !prev_req) begin
                hi_cycles = 0;
                checkOutput("expected_req_queued", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (MEM_REQ) begin
                hi_cycles++;
                if (have_cur) checkOutput("mem_a", {12'd0, MEM_A}, {12'd0, cur.addr});
            end
            if (!MEM_REQ && prev_req) begin
                if (have_cur && W_RESETn) begin
                    if (cur.is_wav) begin
                        checkOutput("wav_d", {24'd0, WAV_D}, {24'd0, cur.data});
                        checkOutput("wav_valid", {31'd0, WAV_VALID}, {31'd0, cur.vld});
                    end else begin
                        checkOutput("cpu_d", {24'd0, CPU_D}, {24'd0, cur.data});
                        checkOutput("cpu_valid", {31'd0, CPU_VALID}, {31'd0, cur.vld});
                    end
                    if (cur.cycles != 0) checkOutput("req_cycles", hi_cycles, cur.cycles);
                end
                have_cur = 1'b0;
                completed++;
            end
            prev_req = MEM_REQ;
        end
    end

    initial begin
        #5 W_RESETn = 1'b0;
        repeat (3) @(negedge W_CLK_24576M);
        checkResetState();

        // Both requesters miss after reset: CPU first, then WAV.
        pushExp(20'h80000, 1'b0, 8'hDA, 1'b1, 3);
        pushExp(20'h00000, 1'b1, 8'h5A, 1'b1, 3);
        @(negedge W_CLK_24576M);
        W_RESETn = 1'b1;
        waitDone(2);

        // Make CPU the last served, then change both at once: WAV must win.
        pushExp(20'h80123, 1'b0, 8'hF9, 1'b1, 3);
        applyStimulus(12'h123, 19'h00000);
        waitDone(3);
        pushExp(20'h12345, 1'b1, 8'h0D, 1'b1, 3);
        pushExp(20'h800FF, 1'b0, 8'h25, 1'b1, 3);
        applyStimulus(12'h0FF, 19'h12345);
        waitDone(5);

        // Address change mid-transfer: stale byte latched but not valid, then refetch.
        pushExp(20'h80010, 1'b0, 8'hCA, 1'b0, 3);
        pushExp(20'h80011, 1'b0, 8'hCB, 1'b1, 3);
        applyStimulus(12'h010, 19'h12345);
        applyStimulus(12'h011, 19'h12345);
        waitDone(7);

        // No acknowledge: both sides time out with their fill values.
        @(negedge W_CLK_24576M);
        ack_en = 1'b0;
        pushExp(20'h80222, 1'b0, 8'hFF, 1'b1, 64);
        applyStimulus(12'h222, 19'h12345);
        waitDone(8);
        checkOutput("timeout_err_set", {31'd0, TIMEOUT_ERR}, 32'd1);
        pushExp(20'h00777, 1'b1, 8'h80, 1'b1, 64);
        applyStimulus(12'h222, 19'h00777);
        waitDone(9);

        @(negedge W_CLK_24576M);
        ack_en = 1'b1;
        pushExp(20'h80300, 1'b0, 8'hDA, 1'b1, 3);
        applyStimulus(12'h300, 19'h00777);
        waitDone(10);
        checkOutput("timeout_err_sticky", {31'd0, TIMEOUT_ERR}, 32'd1);

        // Reset mid WAV transfer, then a stray acknowledge while idle.
        @(negedge W_CLK_24576M);
        ack_en = 1'b0;
        pushExp(20'h40001, 1'b1, 8'h00, 1'b0, 0);
        applyStimulus(12'h300, 19'h40001);
        waitReq();
        @(negedge W_CLK_24576M);
        #3 W_RESETn = 1'b0;
        CPU_A = 12'h456;
        #1 checkResetState();
        waitDone(11);

        pushExp(20'h80456, 1'b0, 8'h8C, 1'b1, 0);
        pushExp(20'h40001, 1'b1, 8'h1B, 1'b1, 0);
        @(negedge W_CLK_24576M);
        MEM_ACK  = 1'b1;
        MEM_D    = 8'h33;
        W_RESETn = 1'b1;
        @(negedge W_CLK_24576M);
        MEM_ACK  = 1'b0;
        ack_en   = 1'b1;
        waitDone(13);

        checkOutput("queue_drained", exp_q.size(), 32'd0);
        repeat (2) @(negedge W_CLK_24576M);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
